// File: rtl/img_pkg.sv
// Shared definitions for the pixel window fetch block: default geometry,
// coordinate width and the frame-sequencing state encoding.
package img_pkg;

  localparam int DW      = 16;
  localparam int MAX_W   = 640;
  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/line_buf_ram.sv
// Single-row line buffer: one write port, one registered read port.
// A read and a write to the same address return the old contents.
module line_buf_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pixel_window_fetch.sv
// Streams a raster image and emits every 2x2 pixel window (top-left at m,n)
// once both rows are available, using one line buffer for the previous row.
module pixel_window_fetch #(
  parameter int DW    = img_pkg::DW,
  parameter int MAX_W = img_pkg::MAX_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [img_pkg::COORD_W-1:0]   sw_val,
  input  logic [img_pkg::COORD_W-1:0]   sh_val,
  input  logic [DW-1:0]                 pix_in,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic [DW-1:0]                 imgmn,
  output logic [DW-1:0]                 imgm1n,
  output logic [DW-1:0]                 imgmn1,
  output logic [DW-1:0]                 imgm1n1,
  output logic                          img_rdy,
  output logic [img_pkg::COORD_W-1:0]   loc_x,
  output logic [img_pkg::COORD_W-1:0]   loc_y,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          cfg_err
);

  import img_pkg::*;

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [COORD_W-1:0] MAX_W_C = COORD_W'(MAX_W);

  state_t              state_reg;
  logic [COORD_W-1:0]  x_reg, y_reg, sw_reg, sh_reg;
  logic [COORD_W-1:0]  loc_x_reg, loc_y_reg;
  logic                pix_ready_reg, busy_reg, img_rdy_reg, frame_done_reg, cfg_err_reg;
  logic [DW-1:0]       left_cur_reg, left_prev_reg;
  logic [DW-1:0]       lb_rd_data;
  logic [AW-1:0]       lb_rd_addr;
  logic [DW-1:0]       win_next [4];
  logic [DW-1:0]       win_q    [4];

  logic transfer, x_last, y_last, cfg_ok, win_upd;

  assign transfer = pix_valid & pix_ready_reg;
  assign x_last   = (x_reg == sw_reg - 16'd1);
  assign y_last   = (y_reg == sh_reg - 16'd1);
  assign cfg_ok   = (sw_val >= 16'd2) && (sw_val <= MAX_W_C) && (sh_val >= 16'd2);
  assign win_upd  = transfer && (state_reg == ST_STREAM) && (x_reg != '0);

  // The read address runs one column ahead of the write, so the previous-row
  // pixel at x is already sitting on lb_rd_data when pixel x is transferred.
  // With sw >= 2 the prefetch never targets the column being written.
  assign lb_rd_addr = transfer ? (x_last ? '0 : AW'(x_reg + 16'd1)) : x_reg[AW-1:0];

  line_buf_ram #(
    .DW    (DW),
    .DEPTH (MAX_W),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (transfer),
    .wr_addr (x_reg[AW-1:0]),
    .wr_data (pix_in),
    .rd_addr (lb_rd_addr),
    .rd_data (lb_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      sw_reg         <= '0;
      sh_reg         <= '0;
      loc_x_reg      <= '0;
      loc_y_reg      <= '0;
      pix_ready_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      img_rdy_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      img_rdy_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;

      if (transfer) begin
        x_reg <= x_last ? '0 : x_reg + 16'd1;
        if (x_last) begin
          y_reg <= y_last ? '0 : y_reg + 16'd1;
        end
      end

      if (win_upd) begin
        img_rdy_reg <= 1'b1;
        loc_x_reg   <= x_reg - 16'd1;
        loc_y_reg   <= y_reg - 16'd1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              sw_reg        <= sw_val;
              sh_reg        <= sh_val;
              x_reg         <= '0;
              y_reg         <= '0;
              state_reg     <= ST_FILL;
              pix_ready_reg <= 1'b1;
              busy_reg      <= 1'b1;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (transfer && x_last) begin
            state_reg <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (transfer && x_last && y_last) begin
            state_reg      <= ST_IDLE;
            pix_ready_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          pix_ready_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  // Left-column registers follow every transfer, including column 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      left_cur_reg  <= '0;
      left_prev_reg <= '0;
    end else if (transfer) begin
      left_cur_reg  <= pix_in;
      left_prev_reg <= lb_rd_data;
    end
  end

  assign win_next[0] = left_prev_reg;
  assign win_next[1] = lb_rd_data;
  assign win_next[2] = left_cur_reg;
  assign win_next[3] = pix_in;

  for (genvar gi = 0; gi < 4; gi++) begin : g_win
    logic [DW-1:0] lane_reg;
    always_ff @(posedge clk) begin
      if (!reset) begin
        lane_reg <= '0;
      end else if (win_upd) begin
        lane_reg <= win_next[gi];
      end
    end
    assign win_q[gi] = lane_reg;
  end

  assign imgmn      = win_q[0];
  assign imgm1n     = win_q[1];
  assign imgmn1     = win_q[2];
  assign imgm1n1    = win_q[3];
  assign pix_ready  = pix_ready_reg;
  assign busy       = busy_reg;
  assign img_rdy    = img_rdy_reg;
  assign frame_done = frame_done_reg;
  assign cfg_err    = cfg_err_reg;
  assign loc_x      = loc_x_reg;
  assign loc_y      = loc_y_reg;

endmodule

// File: doc/pixel_window_fetch.md
PIXEL_WINDOW_FETCH -- requirements
Module: pixel_window_fetch

Interface
REQ-001 Parameter DW, default 16, pixel width in bits.
REQ-002 Parameter MAX_W, default 640, maximum source image width in pixels.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
REQ-006 sw_val  in  16  source width; latched on accepted start.
REQ-007 sh_val  in  16  source height; latched on accepted start.
REQ-008 pix_in  in  DW  raster-order source pixel.
REQ-009 pix_valid  in  1  pix_in valid.
REQ-010 pix_ready  out  1  block can accept a pixel; transfer = pix_valid & pix_ready.
REQ-011 imgmn  out  DW  pixel (m,n), top-left of the window (m = column, n = row).
REQ-012 imgm1n  out  DW  pixel (m+1,n).
REQ-013 imgmn1  out  DW  pixel (m,n+1).
REQ-014 imgm1n1  out  DW  pixel (m+1,n+1).
REQ-015 img_rdy  out  1  one-cycle strobe; the window outputs and loc outputs are valid.
REQ-016 loc_x  out  16  m of the current window.
REQ-017 loc_y  out  16  n of the current window.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 frame_done  out  1  one-cycle pulse coincident with the final img_rdy of a frame.
REQ-020 cfg_err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-021 States: IDLE, FILL (row 0), STREAM (rows 1..sh-1).
- IDLE -> FILL on start with 2<=sw_val<=MAX_W and sh_val>=2.
- Otherwise, a start in IDLE pulses cfg_err the next cycle and the block stays in IDLE.
REQ-022 start outside IDLE is ignored; sw and sh are not relatched.
REQ-023 pix_ready is high in FILL and STREAM and low in IDLE; there is no downstream backpressure.
REQ-024 A column counter x (0..sw-1) and a row counter y (0..sh-1) advance only on a transfer.
- x wraps to 0 at sw-1, and y then increments.
REQ-025 Each transferred pixel is written to line-buffer address x.
- In the same cycle, the previous-row pixel at x is read (read-before-write).
REQ-026 Left-column registers hold the previous current-row pixel and the previous previous-row pixel; they update on every transfer.
REQ-027 In FILL, no img_rdy is generated.
- FILL -> STREAM on the transfer of (sw-1, 0).
REQ-028 In STREAM, a transfer of pixel (x,y) with x>=1 produces a registered window one cycle later:
- imgmn=(x-1,y-1), imgm1n=(x,y-1), imgmn1=(x-1,y), imgm1n1=(x,y);
- loc_x=x-1, loc_y=y-1; img_rdy=1.
REQ-029 Transfers with x=0 produce no img_rdy, so a frame yields exactly (sw-1)*(sh-1) strobes.
REQ-030 On the transfer of (sw-1, sh-1):
- the next cycle carries the final img_rdy together with frame_done;
- the FSM enters IDLE in that same cycle, so pix_ready is low.
REQ-031 Gaps in pix_valid stall the counters and the window; img_rdy stays low during gaps.
REQ-032 Window outputs and loc outputs hold their last values between strobes.

Reset
REQ-033 While reset=0 at a clock edge:
- state=IDLE, x=y=0;
- all outputs 0, including pix_ready, img_rdy, busy, frame_done and cfg_err.
REQ-034 Reset mid-frame aborts the frame with no frame_done; line-buffer contents need not be cleared.

Structure
REQ-035 Shared package img_pkg holds DW, MAX_W, the state enum and the coordinate width (16).
REQ-036 The line buffer is a sub-module line_buf_ram:
- MAX_W x DW, one write port and one read port;
- registered read, read-before-write on the same address;
- address width $clog2(MAX_W).

Verification
REQ-037 Scenario: sw=3, sh=3, pixels 1..9, continuous valid -> 4 strobes in order:
- (1,2,4,5) at loc (0,0);
- (2,3,5,6) at (1,0);
- (4,5,7,8) at (0,1);
- (5,6,8,9) at (1,1), with frame_done on this last strobe.
REQ-038 Scenario: same 3x3 frame with pix_valid toggling every other cycle -> identical window sequence, one strobe per qualifying transfer, no strobes during gaps.
REQ-039 Scenario: start with sw=1 or sh=1 or sw=MAX_W+1 -> cfg_err pulse, busy stays 0, pix_ready stays 0.
REQ-040 Scenario: sw=MAX_W, sh=2 -> MAX_W-1 strobes; the last strobe has loc_x=MAX_W-2, loc_y=0, and frame_done=1.
REQ-041 Scenario: reset asserted after 5 pixels of a 4x4 frame, then a new 3x3 frame of 1..9 -> no frame_done for the aborted frame; the new frame matches REQ-037.
REQ-042 Scenario: start pulsed during STREAM with sw=5 -> ignored; the frame completes with (sw_orig-1)*(sh-1) strobes.
